// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Request/response and RAM-side bus of the memory access
//               controller. The slave modport is the controller's view; the
//               master modport is the requester/RAM environment's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_mode;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport slave (
      input  req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
      input  ram_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
      output ram_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences one load/store at a time onto a single-port
//               synchronous RAM. Accesses crossing a word boundary take two
//               RAM cycles; load data is merged, aligned and extended.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
   input  wire logic     clk,
   input  wire logic     rst,
   mem_access_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE0 = 3'd1,
      ISSUE1 = 3'd2,
      CAPT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nx;

   // Latched request; size kept as two flags (byte is "neither")
   logic        we_q;
   logic        word_q;
   logic        half_q;
   logic        uns_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] lo_q;
   logic [31:0] result_q;

   logic        mode_legal;
   logic [1:0]  off;
   logic [3:0]  base_mask;
   logic [7:0]  lane_mask;
   logic        split;
   logic [63:0] wrot64;
   logic [31:0] wrot;
   logic [31:0] hi_word;
   logic [31:0] lo_word;
   logic [63:0] rd_shift;
   logic [31:0] rd_al;
   logic [31:0] load_ext;

   assign mode_legal = (bus.req_mode == 3'b001) || (bus.req_mode == 3'b010) ||
                       (bus.req_mode == 3'b100);

   // Lane mask over two consecutive words: low nibble hits the first word,
   // high nibble spills into the next one and marks a split access.
   assign off       = addr_q[1:0];
   assign base_mask = word_q ? 4'b1111 : (half_q ? 4'b0011 : 4'b0001);
   assign lane_mask = {4'b0000, base_mask} << off;
   assign split     = |lane_mask[7:4];

   // Rotate-left of the store data so byte 0 lands on lane off
   assign wrot64 = {wdata_q, wdata_q} << {off, 3'b000};
   assign wrot   = wrot64[63:32];

   // Load alignment: with no split the only word read sits in the low half
   assign hi_word  = split ? bus.ram_rdata : 32'h0;
   assign lo_word  = split ? lo_q : bus.ram_rdata;
   assign rd_shift = {hi_word, lo_word} >> {off, 3'b000};
   assign rd_al    = rd_shift[31:0];

   // Size trimming and sign/zero extension of the aligned load data
   always_comb begin
      load_ext = 32'h0;
      if (word_q)
         load_ext = rd_al;
      else if (half_q)
         load_ext = {{16{~uns_q & rd_al[15]}}, rd_al[15:0]};
      else
         load_ext = {{24{~uns_q & rd_al[7]}}, rd_al[7:0]};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Request latch, low-word capture and final result formation
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         word_q   <= 1'b0;
         half_q   <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         lo_q     <= 32'h0;
         result_q <= 32'h0;
      end else begin
         if ((state == IDLE) && bus.req_valid) begin
            we_q     <= bus.req_we;
            word_q   <= bus.req_mode[2];
            half_q   <= bus.req_mode[1];
            uns_q    <= bus.req_unsigned;
            err_q    <= ~mode_legal;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            result_q <= 32'h0;
         end
         if (state == ISSUE1)
            lo_q <= bus.ram_rdata;
         if (state == CAPT)
            result_q <= we_q ? 32'h0 : load_ext;
      end
   end

   // Next-state and output decode from state and latched request only
   always_comb begin
      state_nx       = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 4'b0000;
      bus.ram_addr   = 30'h0;
      bus.ram_wdata  = 32'h0;
      case (state)
         IDLE: begin
            bus.req_ready = ~rst;
            if (bus.req_valid)
               state_nx = mode_legal ? ISSUE0 : RESP;
         end
         ISSUE0: begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = addr_q[31:2];
            if (we_q) begin
               bus.ram_we    = lane_mask[3:0];
               bus.ram_wdata = wrot;
            end
            state_nx = split ? ISSUE1 : CAPT;
         end
         ISSUE1: begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = addr_q[31:2] + 30'd1;
            if (we_q) begin
               bus.ram_we    = lane_mask[7:4];
               bus.ram_wdata = wrot;
            end
            state_nx = CAPT;
         end
         CAPT: begin
            state_nx = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rdata = result_q;
            state_nx       = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed scoreboard bench for mem_access_ctrl with a small
//               synchronous RAM model (4 words, indexed by ram_addr[1:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   cur_is_load = 1'b0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          t_acc;
      int          lat;
   } exp_t;
   exp_t q[$];

   logic [31:0] mem [4];

   mem_access_if bus ();

   mem_access_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: preloaded during reset, read-before-write, one-cycle read
   always @(posedge clk) begin
      if (rst) begin
         mem[0] <= 32'h44332211;
         mem[1] <= 32'h88776655;
         mem[2] <= 32'h00000000;
         mem[3] <= 32'hCAFEF00D;
         bus.ram_rdata <= 32'h0;
      end else if (bus.ram_en) begin
         bus.ram_rdata <= mem[bus.ram_addr[1:0]];
         for (int i = 0; i < 4; i++)
            if (bus.ram_we[i])
               mem[bus.ram_addr[1:0]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard whenever a response pulses
   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_latency", cyc - e.t_acc, e.lat);
         end
      end
      if (bus.ram_en && cur_is_load && !rst)
         chk("load_ram_we", {28'b0, bus.ram_we}, 32'h0);
   end

   // Drive one request at a negedge; returns at the negedge of cycle T+1
   task automatic issue(input logic we, input logic [2:0] mode, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input bit push);
      int n = 0;
      exp_t e;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'd1, 32'd0);
      bus.req_we       = we;
      bus.req_mode     = mode;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
      if (push) begin
         e.err = exp_err; e.rdata = exp_rdata; e.t_acc = cyc; e.lat = exp_lat;
         q.push_back(e);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hX;
      bus.req_wdata = 32'hX;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || !bus.req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("done_timeout", 32'd1, 32'd0);
   endtask

   // Directed stimulus with hand-computed expectations
   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_mode     = 3'b000;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;

      repeat (3) @(negedge clk);
      chk("ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_ram_en", {31'b0, bus.ram_en}, 32'd0);
      chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_ram_we", {28'b0, bus.ram_we}, 32'd0);

      // Byte loads at 0x7
      cur_is_load = 1'b1;
      issue(1'b0, 3'b001, 1'b0, 32'h7, 32'h0, 1'b0, 32'hFFFFFF88, 3, 1'b1);
      chk("bload_addr", {2'b0, bus.ram_addr}, 32'd1);
      wait_done();
      issue(1'b0, 3'b001, 1'b1, 32'h7, 32'h0, 1'b0, 32'h00000088, 3, 1'b1);
      wait_done();

      // Misaligned word load at 0x3
      issue(1'b0, 3'b100, 1'b0, 32'h3, 32'h0, 1'b0, 32'h77665544, 4, 1'b1);
      chk("wload_addr0", {2'b0, bus.ram_addr}, 32'd0);
      @(negedge clk);
      chk("wload_addr1", {2'b0, bus.ram_addr}, 32'd1);
      wait_done();

      // Aligned signed half load at 0x6
      issue(1'b0, 3'b010, 1'b0, 32'h6, 32'h0, 1'b0, 32'hFFFF8877, 3, 1'b1);
      wait_done();

      // Misaligned half store at 0x3
      cur_is_load = 1'b0;
      issue(1'b1, 3'b010, 1'b0, 32'h3, 32'h0000ABCD, 1'b0, 32'h0, 4, 1'b1);
      chk("hst_addr0", {2'b0, bus.ram_addr}, 32'd0);
      chk("hst_we0", {28'b0, bus.ram_we}, 32'h8);
      chk("hst_wdata0", bus.ram_wdata, 32'hCD0000AB);
      @(negedge clk);
      chk("hst_addr1", {2'b0, bus.ram_addr}, 32'd1);
      chk("hst_we1", {28'b0, bus.ram_we}, 32'h1);
      chk("hst_wdata1", bus.ram_wdata, 32'hCD0000AB);
      wait_done();
      chk("hst_mem0", mem[0], 32'hCD332211);
      chk("hst_mem1", mem[1], 32'h887766AB);

      // Read back across the boundary
      cur_is_load = 1'b1;
      issue(1'b0, 3'b100, 1'b0, 32'h3, 32'h0, 1'b0, 32'h7766ABCD, 4, 1'b1);
      wait_done();

      // Illegal modes
      issue(1'b0, 3'b011, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 1'b1);
      chk("ill_ram_en_t1", {31'b0, bus.ram_en}, 32'd0);
      @(negedge clk);
      chk("ill_ram_en_t2", {31'b0, bus.ram_en}, 32'd0);
      chk("ill_ready_t2", {31'b0, bus.req_ready}, 32'd1);
      issue(1'b1, 3'b000, 1'b0, 32'h4, 32'h12345678, 1'b1, 32'h0, 1, 1'b1);
      chk("ill0_ram_en", {31'b0, bus.ram_en}, 32'd0);
      wait_done();

      // Word-address wrap-around
      issue(1'b0, 3'b100, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h2211CAFE, 4, 1'b1);
      chk("wrap_addr0", {2'b0, bus.ram_addr}, 32'h3FFFFFFF);
      @(negedge clk);
      chk("wrap_addr1", {2'b0, bus.ram_addr}, 32'd0);
      wait_done();

      // Aligned word store then load of the other word
      cur_is_load = 1'b0;
      issue(1'b1, 3'b100, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 3, 1'b1);
      chk("wst_en", {31'b0, bus.ram_en}, 32'd1);
      chk("wst_addr", {2'b0, bus.ram_addr}, 32'd0);
      chk("wst_we", {28'b0, bus.ram_we}, 32'hF);
      chk("wst_wdata", bus.ram_wdata, 32'hDEADBEEF);
      wait_done();
      chk("wst_mem0", mem[0], 32'hDEADBEEF);
      cur_is_load = 1'b1;
      issue(1'b0, 3'b100, 1'b1, 32'h4, 32'h0, 1'b0, 32'h887766AB, 3, 1'b1);
      wait_done();

      // Reset abort during ISSUE1 of a split store
      cur_is_load = 1'b0;
      issue(1'b1, 3'b100, 1'b0, 32'h1, 32'h11223344, 1'b0, 32'h0, 0, 1'b0);
      @(negedge clk);
      chk("abort_issue1_en", {31'b0, bus.ram_en}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ram_en", {31'b0, bus.ram_en}, 32'd0);
      chk("abort_resp", {31'b0, bus.resp_valid}, 32'd0);
      chk("abort_ready_rst", {31'b0, bus.req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'b0, bus.req_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("abort_idle_en", {31'b0, bus.ram_en}, 32'd0);
         @(negedge clk);
      end

      wait_done();
      chk("queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller between the load/store stage and the single-port synchronous data RAM. It accepts one load or store request at a time and generates the per-byte write enables and rotated write data for stores. It splits word/half accesses that cross a 32-bit word boundary into two RAM cycles, then merges, aligns and sign/zero-extends load data before returning a single response.

## Interface
- No parameters; data path fixed at 32 bits, RAM word address 30 bits.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted on req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_mode  in  3  one-hot size: [2] word, [1] half, [0] byte
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0); ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  request had an illegal mode; valid with resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- ram_en  out  1  RAM access this cycle
- ram_we  out  4  byte write enables, bit i = byte lane i; 0 on reads
- ram_addr  out  30  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid the cycle after a read ram_en

## Operation
- FSM states: IDLE, ISSUE0, ISSUE1, CAPT, RESP.
- IDLE: req_ready=1. On accept, latch all req_* fields. Illegal mode (zero or multi-hot) -> RESP with err. Otherwise -> ISSUE0.
- off = addr[1:0]; n = 4/2/1 bytes. split = off+n > 4. This covers a word at off 1-3 and a half at off 3. Bytes never split.
- ISSUE0: ram_en=1, ram_addr=addr[31:2]. Store mask covers lanes off..min(off+n-1,3). Next state is ISSUE1 if split, else CAPT.
- ISSUE1: ram_en=1, ram_addr=addr[31:2]+1, wrapping modulo 2^30 (0x3FFFFFFF -> 0). Store mask covers lanes 0..off+n-5. Capture ram_rdata as the low word. Next state is CAPT.
- CAPT: ram_en=0. Capture ram_rdata as the last word: the high word if split, otherwise the low word. Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store data: ram_wdata = req_wdata rotated left by 8*off bits, identical in both accesses. The masks select the lanes.
- Load data: {high,low} >> 8*off, low n bytes kept, extended per req_unsigned.
- Loads drive ram_we=0. Stores ignore ram_rdata.
- Reset value of every output: 0, except req_ready. req_ready = (state==IDLE) & !rst.
- RAM and response outputs are registered from the state and latched request.

## Timing
- Accept at cycle T.
- Aligned access: ISSUE0 at T+1, CAPT at T+2, resp_valid at T+3, req_ready at T+4.
- Split access: ISSUE0 at T+1, ISSUE1 at T+2, CAPT at T+3, resp_valid at T+4, req_ready at T+5.
- Illegal mode: resp_valid and resp_err at T+1; no ram_en at any cycle; req_ready at T+2.
- No back-to-back acceptance: req_ready is low from T+1 until the controller returns to IDLE.
- Request inputs are don't-care after acceptance.
- rst high in any state: the next state is IDLE and all outputs are 0 from the following cycle.
  - Any pending access is dropped. A split store reset after ISSUE0 leaves only the first lane group written; this is accepted behaviour.
  - No response is issued for the aborted request.
- No response-side backpressure: the requester must take resp_valid when it pulses.

## Test plan
RAM is preloaded with word0=0x44332211 and word1=0x88776655.
- Aligned word store: addr 0x0, data 0xDEADBEEF -> at T+1 ram_en=1, ram_addr=0, ram_we=4'b1111, ram_wdata=0xDEADBEEF. resp_valid at T+3, resp_rdata=0.
- Byte load at addr 0x7: signed -> resp_rdata=0xFFFFFF88 at T+3. Unsigned -> 0x00000088. ram_we=0 throughout.
- Misaligned word load at addr 0x3 -> ram_addr=0 at T+1, ram_addr=1 at T+2, resp_rdata=0x77665544 at T+4.
- Misaligned half store at addr 0x3, data 0x0000ABCD:
  - T+1: ram_addr=0, ram_we=4'b1000, ram_wdata=0xCD0000AB.
  - T+2: ram_addr=1, ram_we=4'b0001, same wdata.
  - Result: word0=0xCD332211, word1=0x887766AB.
- Illegal mode 3'b011 -> resp_valid=1 and resp_err=1 at T+1, ram_en never asserted.
- Wrap-around: word load at addr 0xFFFFFFFE -> second access at ram_addr=0.
- Reset abort: rst pulsed during ISSUE1 of a split store -> no ram_en and no resp_valid afterwards; req_ready=1 the cycle after rst drops.
